// File: rtl/mem_ctrl_mc_seq_if.sv
// CSR bus and memory-PHY beat handshake bundle for the multi-channel burst controller.
// The controller connects through the slave modport; the bus owner / PHY model uses master.
interface mem_ctrl_mc_seq_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) ();
  // CSR side
  logic                  csr_wr_en;
  logic                  csr_rd_en;
  logic [ADDR_W-1:0]     csr_addr;
  logic [DATA_W-1:0]     csr_wr_data;
  logic [DATA_W-1:0]     csr_rd_data;
  logic                  csr_rd_valid;
  // memory PHY side
  logic [NUM_CH*4-1:0]   mem_mode;
  logic [NUM_CH-1:0]     mem_beat_valid;
  logic [NUM_CH-1:0]     mem_beat_ready;
  logic [NUM_CH-1:0]     mem_busy;
  // status
  logic                  irq;
  logic                  error_flag;

  modport slave (
    input  csr_wr_en, csr_rd_en, csr_addr, csr_wr_data, mem_beat_ready,
    output csr_rd_data, csr_rd_valid, mem_mode, mem_beat_valid, mem_busy, irq, error_flag
  );

  modport master (
    output csr_wr_en, csr_rd_en, csr_addr, csr_wr_data, mem_beat_ready,
    input  csr_rd_data, csr_rd_valid, mem_mode, mem_beat_valid, mem_busy, irq, error_flag
  );
endinterface

// File: rtl/mem_ctrl_mc_seq.sv
// Multi-channel memory controller CSR block with a per-channel burst sequencer.
// Each channel waits CFG.latency cycles after a start, then issues CFG.burst_len
// beats over valid/ready. Channel c registers live at c*0x10; globals at 0xF0..0xF8.
module mem_ctrl_mc_seq #(
  parameter int          NUM_CH   = 4,
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] ID_VALUE = 32'h1234_ABCE
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_ctrl_mc_seq_if.slave bus
);

  localparam int CH_AW = ADDR_W - 4;
  localparam logic [ADDR_W-1:0] ADDR_ID     = ADDR_W'(8'hF0);
  localparam logic [ADDR_W-1:0] ADDR_IRQ_EN = ADDR_W'(8'hF4);
  localparam logic [ADDR_W-1:0] ADDR_GERR   = ADDR_W'(8'hF8);

  typedef enum logic [1:0] {ST_IDLE, ST_LAT, ST_BURST, ST_DONE} state_t;

  // per-channel state
  state_t      r_state      [NUM_CH];
  state_t      w_state_next [NUM_CH];
  logic [3:0]  r_lat_cnt    [NUM_CH];
  logic [3:0]  w_lat_next   [NUM_CH];
  logic [7:0]  r_beat_cnt   [NUM_CH];
  logic [7:0]  w_beat_next  [NUM_CH];
  logic [3:0]  w_err_set    [NUM_CH];
  logic [3:0]  r_mode       [NUM_CH];
  logic [11:0] r_cfg        [NUM_CH];
  logic [3:0]  r_err        [NUM_CH];

  // global registers
  logic [NUM_CH:0]   r_irq_en;
  logic [1:0]        r_gerr;
  logic [1:0]        w_gerr_set;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] w_rd_data;
  logic              r_rd_valid;
  logic              r_irq;
  logic              r_err_flag;
  logic              w_irq;
  logic              w_err_any;

  // address decode
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_off;
  logic [NUM_CH-1:0] w_ch_hit;
  logic [NUM_CH-1:0] w_ctrl_wr;
  logic [NUM_CH-1:0] w_cfg_wr;
  logic [NUM_CH-1:0] w_err_wr;
  logic [NUM_CH-1:0] w_start;
  logic [NUM_CH-1:0] w_abort;
  logic [NUM_CH-1:0] w_busy;
  logic              w_irq_en_wr;
  logic              w_gerr_wr;
  logic              w_unused;

  assign w_addr      = {bus.csr_addr[ADDR_W-1:2], 2'b00};
  assign w_off       = bus.csr_addr[3:2];
  assign w_irq_en_wr = bus.csr_wr_en && (w_addr == ADDR_IRQ_EN);
  assign w_gerr_wr   = bus.csr_wr_en && (w_addr == ADDR_GERR);
  // byte-lane bits and upper write-data bits carry no information here
  assign w_unused    = ^{bus.csr_addr[1:0], bus.csr_wr_data};

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_ch_hit[gi]  = (bus.csr_addr[ADDR_W-1:4] == CH_AW'(gi));
      assign w_ctrl_wr[gi] = bus.csr_wr_en && w_ch_hit[gi] && (w_off == 2'd0);
      assign w_cfg_wr[gi]  = bus.csr_wr_en && w_ch_hit[gi] && (w_off == 2'd2);
      assign w_err_wr[gi]  = bus.csr_wr_en && w_ch_hit[gi] && (w_off == 2'd3);
      assign w_start[gi]   = w_ctrl_wr[gi] && bus.csr_wr_data[0];
      assign w_abort[gi]   = w_ctrl_wr[gi] && bus.csr_wr_data[5];
      assign w_busy[gi]    = (r_state[gi] != ST_IDLE);

      assign bus.mem_mode[gi*4 +: 4] = r_mode[gi];
      assign bus.mem_beat_valid[gi]  = (r_state[gi] == ST_BURST);
      assign bus.mem_busy[gi]        = w_busy[gi];
    end
  endgenerate

  assign bus.csr_rd_data  = r_rd_data;
  assign bus.csr_rd_valid = r_rd_valid;
  assign bus.irq          = r_irq;
  assign bus.error_flag   = r_err_flag;

  // sequencer next-state: launch, latency countdown, beat countdown, abort and error events
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_state_next[c] = r_state[c];
      w_lat_next[c]   = r_lat_cnt[c];
      w_beat_next[c]  = r_beat_cnt[c];
      w_err_set[c]    = 4'd0;
      case (r_state[c])
        ST_IDLE: begin
          // abort in the same write suppresses the launch entirely
          if (w_start[c] && !w_abort[c]) begin
            if (r_cfg[c][7:0] == 8'd0) begin
              w_err_set[c][2] = 1'b1;
            end else begin
              w_beat_next[c]  = r_cfg[c][7:0];
              w_lat_next[c]   = r_cfg[c][11:8];
              w_state_next[c] = (r_cfg[c][11:8] == 4'd0) ? ST_BURST : ST_LAT;
            end
          end
        end
        ST_LAT: begin
          w_err_set[c][1] = w_start[c];
          if (w_abort[c]) begin
            w_err_set[c][3] = 1'b1;
            w_lat_next[c]   = 4'd0;
            w_beat_next[c]  = 8'd0;
            w_state_next[c] = ST_IDLE;
          end else if (r_lat_cnt[c] <= 4'd1) begin
            w_lat_next[c]   = 4'd0;
            w_state_next[c] = ST_BURST;
          end else begin
            w_lat_next[c]   = r_lat_cnt[c] - 4'd1;
          end
        end
        ST_BURST: begin
          w_err_set[c][1] = w_start[c];
          if (w_abort[c]) begin
            w_err_set[c][3] = 1'b1;
            w_beat_next[c]  = 8'd0;
            w_state_next[c] = ST_IDLE;
          end else if (bus.mem_beat_ready[c]) begin
            w_beat_next[c] = r_beat_cnt[c] - 8'd1;
            if (r_beat_cnt[c] == 8'd1) begin
              w_state_next[c] = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          w_err_set[c][1] = w_start[c];
          w_err_set[c][0] = 1'b1;
          w_state_next[c] = ST_IDLE;
        end
        default: begin
          w_state_next[c] = ST_IDLE;
        end
      endcase
    end
  end

  // sequencer state register; reset drops any burst in flight without flagging it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c]    <= ST_IDLE;
        r_lat_cnt[c]  <= 4'd0;
        r_beat_cnt[c] <= 8'd0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c]    <= w_state_next[c];
        r_lat_cnt[c]  <= w_lat_next[c];
        r_beat_cnt[c] <= w_beat_next[c];
      end
    end
  end

  // read mux over the current register contents (pre-write view for a colliding write)
  always_comb begin
    w_rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch_hit[c]) begin
        case (w_off)
          2'd0:    w_rd_data = DATA_W'({r_mode[c], 1'b0});
          2'd1:    w_rd_data = DATA_W'({r_beat_cnt[c], 6'd0, (r_state[c] == ST_LAT), w_busy[c]});
          2'd2:    w_rd_data = DATA_W'(r_cfg[c]);
          default: w_rd_data = DATA_W'(r_err[c]);
        endcase
      end
    end
    if (w_addr == ADDR_ID)     w_rd_data = DATA_W'(ID_VALUE);
    if (w_addr == ADDR_IRQ_EN) w_rd_data = DATA_W'(r_irq_en);
    if (w_addr == ADDR_GERR)   w_rd_data = DATA_W'(r_gerr);
  end

  // global error sources and interrupt/error summaries
  always_comb begin
    w_gerr_set[0] = bus.csr_rd_en && bus.csr_wr_en;
    w_gerr_set[1] = |(w_cfg_wr & w_busy);
    w_irq         = r_irq_en[NUM_CH] & (|r_gerr);
    w_err_any     = |r_gerr;
    for (int c = 0; c < NUM_CH; c++) begin
      w_irq     = w_irq | (r_err[c][0] & r_irq_en[c]) | (r_irq_en[NUM_CH] & (|r_err[c][3:1]));
      w_err_any = w_err_any | (|r_err[c][3:1]);
    end
  end

  // CSR storage, W1C sticky bits (new events win over a same-cycle clear), read pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_mode[c] <= 4'd0;
        r_cfg[c]  <= 12'd0;
        r_err[c]  <= 4'd0;
      end
      r_irq_en   <= '0;
      r_gerr     <= 2'd0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_irq      <= 1'b0;
      r_err_flag <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ctrl_wr[c]) r_mode[c] <= bus.csr_wr_data[4:1];
        if (w_cfg_wr[c] && !w_busy[c]) r_cfg[c] <= bus.csr_wr_data[11:0];
        r_err[c] <= (r_err[c] & ~(w_err_wr[c] ? bus.csr_wr_data[3:0] : 4'd0)) | w_err_set[c];
      end
      if (w_irq_en_wr) r_irq_en <= bus.csr_wr_data[NUM_CH:0];
      r_gerr     <= (r_gerr & ~(w_gerr_wr ? bus.csr_wr_data[1:0] : 2'd0)) | w_gerr_set;
      r_rd_valid <= bus.csr_rd_en;
      if (bus.csr_rd_en) r_rd_data <= w_rd_data;
      r_irq      <= w_irq;
      r_err_flag <= w_err_any;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_mc_seq.sv
// Directed bench for mem_ctrl_mc_seq: a CSR vector table followed by hand-written
// burst, handshake, abort, collision and reset sequences.
module tb_mem_ctrl_mc_seq;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam logic [31:0] ID = 32'h1234_ABCE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_mc_seq_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  mem_ctrl_mc_seq #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_VALUE(ID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // one CSR cycle driven from a falling edge; result sampled on the next falling edge
  task automatic csr_op(input logic wr, input logic rd, input logic [7:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic rvalid);
    @(negedge clk);
    bus_if.csr_wr_en   = wr;
    bus_if.csr_rd_en   = rd;
    bus_if.csr_addr    = addr;
    bus_if.csr_wr_data = wdata;
    @(negedge clk);
    bus_if.csr_wr_en = 1'b0;
    bus_if.csr_rd_en = 1'b0;
    rdata  = bus_if.csr_rd_data;
    rvalid = bus_if.csr_rd_valid;
  endtask

  task automatic csr_wr(input logic [7:0] addr, input logic [31:0] wdata);
    logic [31:0] d;
    logic v;
    csr_op(1'b1, 1'b0, addr, wdata, d, v);
    $display("wr   addr 0x%02h <= 0x%08h", addr, wdata);
  endtask

  task automatic csr_rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic v;
    csr_op(1'b0, 1'b1, addr, 32'd0, d, v);
    check(name, v ? d : 32'hDEAD_0000, exp);
  endtask

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    logic [31:0] rd;
    logic        rv;
    int lat_c, val_c, vc, acc;
    bit seen, done, gap;

    bus_if.csr_wr_en      = 1'b0;
    bus_if.csr_rd_en      = 1'b0;
    bus_if.csr_addr       = '0;
    bus_if.csr_wr_data    = '0;
    bus_if.mem_beat_ready = '0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_outputs", {bus_if.csr_rd_data[15:0], bus_if.mem_mode, bus_if.mem_beat_valid,
                          bus_if.mem_busy, bus_if.csr_rd_valid, bus_if.irq, bus_if.error_flag, 5'd0}, 32'd0);
    rst_n = 1'b1;

    // ---------------- CSR vector table ----------------
    vecs[0]  = '{wr:1'b0, rd:1'b1, addr:8'hF0, wdata:32'd0,         exp:ID};
    vecs[1]  = '{wr:1'b0, rd:1'b1, addr:8'h04, wdata:32'd0,         exp:32'd0};
    vecs[2]  = '{wr:1'b0, rd:1'b1, addr:8'h18, wdata:32'd0,         exp:32'd0};
    vecs[3]  = '{wr:1'b0, rd:1'b1, addr:8'hF4, wdata:32'd0,         exp:32'd0};
    vecs[4]  = '{wr:1'b1, rd:1'b0, addr:8'h18, wdata:32'h0000_0308, exp:32'd0};
    vecs[5]  = '{wr:1'b0, rd:1'b1, addr:8'h18, wdata:32'd0,         exp:32'h0000_0308};
    vecs[6]  = '{wr:1'b0, rd:1'b1, addr:8'h1B, wdata:32'd0,         exp:32'h0000_0308};
    vecs[7]  = '{wr:1'b1, rd:1'b0, addr:8'h28, wdata:32'hFFFF_FFFF, exp:32'd0};
    vecs[8]  = '{wr:1'b0, rd:1'b1, addr:8'h28, wdata:32'd0,         exp:32'h0000_0FFF};
    vecs[9]  = '{wr:1'b1, rd:1'b0, addr:8'hF0, wdata:32'h0000_FFFF, exp:32'd0};
    vecs[10] = '{wr:1'b0, rd:1'b1, addr:8'hF0, wdata:32'd0,         exp:ID};
    vecs[11] = '{wr:1'b1, rd:1'b0, addr:8'h14, wdata:32'h0000_FFFF, exp:32'd0};
    vecs[12] = '{wr:1'b0, rd:1'b1, addr:8'h14, wdata:32'd0,         exp:32'd0};
    vecs[13] = '{wr:1'b1, rd:1'b0, addr:8'hF4, wdata:32'hFFFF_FFFF, exp:32'd0};
    vecs[14] = '{wr:1'b0, rd:1'b1, addr:8'hF4, wdata:32'd0,         exp:32'h0000_001F};
    vecs[15] = '{wr:1'b1, rd:1'b0, addr:8'hF4, wdata:32'd0,         exp:32'd0};
    vecs[16] = '{wr:1'b0, rd:1'b1, addr:8'hE0, wdata:32'd0,         exp:32'd0};
    vecs[17] = '{wr:1'b1, rd:1'b0, addr:8'h10, wdata:32'h0000_001E, exp:32'd0};
    vecs[18] = '{wr:1'b0, rd:1'b1, addr:8'h10, wdata:32'd0,         exp:32'h0000_001E};

    for (int i = 0; i < 19; i++) begin
      csr_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, rd, rv);
      if (vecs[i].rd) begin
        check($sformatf("vec%0d_rd_valid", i), {31'd0, rv}, 32'd1);
        check($sformatf("vec%0d_rd 0x%02h", i, vecs[i].addr), rd, vecs[i].exp);
      end else begin
        $display("wr   addr 0x%02h <= 0x%08h", vecs[i].addr, vecs[i].wdata);
      end
    end
    check("mem_mode_ch1", bus_if.mem_mode, 32'h0000_00F0);

    // ---------------- 1: ch1 len 8 lat 3, ready high ----------------
    bus_if.mem_beat_ready = 4'hF;
    csr_wr(8'h10, 32'h1);
    check("t1_busy_next_cycle", bus_if.mem_busy[1], 32'd1);
    lat_c = 0; val_c = 0; seen = 0; done = 0;
    for (int k = 0; k < 60; k++) begin
      if (!bus_if.mem_busy[1]) begin
        done = 1;
        break;
      end
      if (bus_if.mem_beat_valid[1]) begin
        seen = 1;
        val_c++;
      end else if (!seen) begin
        lat_c++;
      end
      @(negedge clk);
    end
    check("t1_completed", {31'd0, done}, 32'd1);
    check("t1_lat_cycles", lat_c, 32'd3);
    check("t1_valid_cycles", val_c, 32'd8);
    csr_rd_chk("t1_error_ch1", 8'h1C, 32'h1);
    csr_wr(8'hF4, 32'h2);
    @(negedge clk);
    check("t1_irq_done", bus_if.irq, 32'd1);
    csr_wr(8'h1C, 32'h1);
    @(negedge clk);
    check("t1_irq_cleared", bus_if.irq, 32'd0);
    csr_rd_chk("t1_error_w1c", 8'h1C, 32'h0);
    csr_wr(8'hF4, 32'h0);

    // ---------------- 2: ch0 len 4 lat 0, ready 1010... ----------------
    bus_if.mem_beat_ready[0] = 1'b0;
    csr_wr(8'h08, 32'h0004);
    csr_wr(8'h00, 32'h1);
    vc = 0; acc = 0; done = 0; gap = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus_if.mem_busy[0]) begin
        done = 1;
        break;
      end
      if (bus_if.mem_beat_valid[0]) begin
        bus_if.mem_beat_ready[0] = (vc % 2 == 0);
        if (vc % 2 == 0) acc++;
        vc++;
      end else begin
        bus_if.mem_beat_ready[0] = 1'b0;
        if (vc > 0 && acc < 4) gap = 1;
      end
      @(negedge clk);
    end
    bus_if.mem_beat_ready[0] = 1'b0;
    check("t2_completed", {31'd0, done}, 32'd1);
    check("t2_valid_cycles", vc, 32'd7);
    check("t2_accepted", acc, 32'd4);
    check("t2_valid_held", {31'd0, gap}, 32'd0);
    csr_rd_chk("t2_error_ch0", 8'h0C, 32'h1);
    csr_wr(8'h0C, 32'h1);

    // ---------------- 3: ch2 start with len 0 ----------------
    csr_wr(8'h28, 32'h0500);
    csr_wr(8'h20, 32'h1);
    check("t3_idle", bus_if.mem_busy[2], 32'd0);
    csr_rd_chk("t3_error_len0", 8'h2C, 32'h4);
    csr_wr(8'h2C, 32'h4);
    csr_rd_chk("t3_error_w1c", 8'h2C, 32'h0);

    // ---------------- 4: ch0 restart / cfg-while-busy / abort ----------------
    csr_wr(8'h08, 32'h0010);
    csr_wr(8'h00, 32'h1);
    repeat (2) @(negedge clk);
    check("t4_valid_waiting", bus_if.mem_beat_valid[0], 32'd1);
    csr_rd_chk("t4_status", 8'h04, 32'h0000_1001);
    csr_wr(8'h08, 32'h0020);
    csr_rd_chk("t4_cfg_unchanged", 8'h08, 32'h0010);
    csr_rd_chk("t4_gerr_cfg_busy", 8'hF8, 32'h2);
    csr_wr(8'hF8, 32'h2);
    csr_rd_chk("t4_gerr_w1c", 8'hF8, 32'h0);
    csr_wr(8'h00, 32'h1);
    csr_rd_chk("t4_error_start_busy", 8'h0C, 32'h2);
    check("t4_still_valid", bus_if.mem_beat_valid[0], 32'd1);
    csr_wr(8'h00, 32'h20);
    check("t4_abort_valid_low", {bus_if.mem_beat_valid[0], bus_if.mem_busy[0]}, 32'd0);
    csr_rd_chk("t4_error_abort", 8'h0C, 32'hA);
    check("t4_irq_masked", bus_if.irq, 32'd0);
    csr_wr(8'hF4, 32'h10);
    @(negedge clk);
    check("t4_irq_error", bus_if.irq, 32'd1);
    check("t4_error_flag", bus_if.error_flag, 32'd1);
    csr_wr(8'h0C, 32'hF);
    @(negedge clk);
    check("t4_irq_cleared", {bus_if.irq, bus_if.error_flag}, 32'd0);

    // ---------------- 5: read/write collision on ch3 CFG ----------------
    csr_wr(8'h38, 32'h0123);
    csr_op(1'b1, 1'b1, 8'h38, 32'h0456, rd, rv);
    check("t5_collision_valid", {31'd0, rv}, 32'd1);
    check("t5_collision_old", rd, 32'h0123);
    csr_rd_chk("t5_cfg_new", 8'h38, 32'h0456);
    csr_rd_chk("t5_gerr", 8'hF8, 32'h1);
    check("t5_error_flag", bus_if.error_flag, 32'd1);
    csr_wr(8'hF8, 32'h1);
    csr_rd_chk("t5_gerr_w1c", 8'hF8, 32'h0);

    // ---------------- 6: ID, then reset mid-burst ----------------
    csr_rd_chk("t6_id", 8'hF0, ID);
    csr_wr(8'h20, 32'h1);
    csr_wr(8'h00, 32'h1E);
    bus_if.mem_beat_ready = 4'hF;
    csr_wr(8'h10, 32'h1);
    repeat (5) @(negedge clk);
    check("t6_pre_valid_irq", {bus_if.mem_beat_valid[1], bus_if.irq}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_outputs", {bus_if.csr_rd_data[15:0], bus_if.mem_mode, bus_if.mem_beat_valid,
                             bus_if.mem_busy, bus_if.csr_rd_valid, bus_if.irq, bus_if.error_flag, 5'd0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      csr_rd_chk($sformatf("t6_error_ch%0d", c), 8'((c << 4) | 12), 32'h0);
    end
    csr_rd_chk("t6_status_ch1", 8'h14, 32'h0);
    csr_rd_chk("t6_cfg_ch1", 8'h18, 32'h0);
    csr_rd_chk("t6_irq_en", 8'hF4, 32'h0);
    csr_rd_chk("t6_gerr", 8'hF8, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
